// File: rtl/nexys_starship_pkg.sv
// Shared lane indices, spawn FSM encoding and small helpers for the starship spawn controller.
package nexys_starship_pkg;

   localparam logic [1:0] LANE_TOP   = 2'd0;
   localparam logic [1:0] LANE_BTM   = 2'd1;
   localparam logic [1:0] LANE_LEFT  = 2'd2;
   localparam logic [1:0] LANE_RIGHT = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      PICK  = 2'd2,
      SPAWN = 2'd3
   } spawn_state_t;

   // Scan downward so the lane right after 'last' is the final (winning) match.
   function automatic logic [1:0] rr_grant(input logic [3:0] cand, input logic [1:0] last);
      logic [1:0] lane;
      logic [1:0] idx;
      lane = last;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (cand[idx]) lane = idx;
      end
      return lane;
   endfunction

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/nexys_starship_lane_timer.sv
// Per-lane monster lifetime timer; only compiled when NEXYS_STARSHIP_SPAWN_TIMEOUT_EN is defined.
`ifdef NEXYS_STARSHIP_SPAWN_TIMEOUT_EN
module nexys_starship_lane_timer #(
   parameter int LIFETIME = 200000,
   parameter int LIFE_W   = 18
) (
   input  logic Clk,
   input  logic Reset,
   input  logic load,
   input  logic active,
   input  logic kill,
   output logic expire
);

   logic [LIFE_W-1:0] count;

   // A kill landing in the expiry cycle takes priority, so it suppresses expire.
   assign expire = active & ~kill & ~load & (count <= LIFE_W'(1));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count <= '0;
      end else if (load) begin
         count <= LIFE_W'(LIFETIME);
      end else if (active && count != '0) begin
         count <= count - LIFE_W'(1);
      end
   end

endmodule
`endif

// File: rtl/nexys_starship_spawn_ctrl.sv
// Monster spawn controller: cooldown, round-robin lane pick and occupancy tracking.
// Optional per-lane lifetime timeouts are enabled with NEXYS_STARSHIP_SPAWN_TIMEOUT_EN.
module nexys_starship_spawn_ctrl
   import nexys_starship_pkg::*;
#(
   parameter int COOLDOWN_BASE = 50000,
   parameter int CD_W          = 16,
   parameter int MAX_ACTIVE    = 3,
   parameter int LIFETIME      = 200000,
   parameter int LIFE_W        = 18
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       game_active,
   input  logic [1:0] level,
   input  logic [3:0] rand_in,
   input  logic [3:0] kill,
   output logic [3:0] monster,
   output logic       spawn_pulse,
   output logic [1:0] spawn_lane,
   output logic [2:0] active_count,
   output logic [3:0] timeout
);

   localparam logic [CD_W-1:0] CD_BASE = CD_W'(COOLDOWN_BASE);
   localparam logic [2:0]      MAX_ACT = 3'(MAX_ACTIVE);

   spawn_state_t    state;
   logic [CD_W-1:0] cooldown;
   logic [CD_W-1:0] cd_reload;
   logic [1:0]      grant;
   logic [1:0]      last_grant;
   logic [3:0]      candidates;
   logic [3:0]      spawn_set;
   logic [3:0]      expire;
   logic [3:0]      monster_next;

   assign cd_reload    = CD_BASE >> level;
   assign candidates   = rand_in & ~monster;
   assign spawn_set    = (state == SPAWN) ? (4'b0001 << grant) : 4'b0000;
   // Spawn is OR-ed in last so it beats a same-lane kill on the same edge.
   assign monster_next = (monster & ~kill & ~expire) | spawn_set;

`ifdef NEXYS_STARSHIP_SPAWN_TIMEOUT_EN
   for (genvar i = 0; i < 4; i++) begin : g_lane_timer
      nexys_starship_lane_timer #(
         .LIFETIME (LIFETIME),
         .LIFE_W   (LIFE_W)
      ) u_timer (
         .Clk    (Clk),
         .Reset  (Reset),
         .load   (spawn_set[i] & game_active),
         .active (monster[i]),
         .kill   (kill[i]),
         .expire (expire[i])
      );
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         timeout <= '0;
      end else begin
         timeout <= game_active ? expire : 4'b0000;
      end
   end
`else
   logic unused_lifetime_cfg;
   assign unused_lifetime_cfg = ^LIFE_W'(LIFETIME);
   assign expire  = 4'b0000;
   assign timeout = 4'b0000;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         cooldown     <= '0;
         grant        <= LANE_TOP;
         last_grant   <= LANE_RIGHT;
         monster      <= '0;
         spawn_pulse  <= 1'b0;
         spawn_lane   <= LANE_TOP;
         active_count <= '0;
      end else if (!game_active) begin
         state        <= IDLE;
         monster      <= '0;
         active_count <= '0;
         spawn_pulse  <= 1'b0;
      end else begin
         monster      <= monster_next;
         active_count <= popcount4(monster_next);
         spawn_pulse  <= 1'b0;
         case (state)
            IDLE: begin
               cooldown <= cd_reload;
               state    <= WAIT;
            end
            WAIT: begin
               if (cooldown != '0) cooldown <= cooldown - CD_W'(1);
               if (cooldown <= CD_W'(1)) state <= PICK;
            end
            PICK: begin
               if (candidates != 4'b0000 && active_count < MAX_ACT) begin
                  grant <= rr_grant(candidates, last_grant);
                  state <= SPAWN;
               end
            end
            SPAWN: begin
               spawn_pulse <= 1'b1;
               spawn_lane  <= grant;
               last_grant  <= grant;
               cooldown    <= cd_reload;
               state       <= WAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nexys_starship_spawn_ctrl.sv
// Self-checking bench: directed vector table, corner-case sequences and a randomized run against a timeline model.
module tb_nexys_starship_spawn_ctrl;

   localparam int COOLDOWN_BASE = 8;
   localparam int CD_W          = 16;
   localparam int MAX_ACTIVE    = 3;
   localparam int LIFETIME      = 20;
   localparam int LIFE_W        = 18;
`ifdef NEXYS_STARSHIP_SPAWN_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic       game_active;
   logic [1:0] level;
   logic [3:0] rand_in;
   logic [3:0] kill;
   logic [3:0] monster;
   logic       spawn_pulse;
   logic [1:0] spawn_lane;
   logic [2:0] active_count;
   logic [3:0] timeout;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   nexys_starship_spawn_ctrl #(
      .COOLDOWN_BASE (COOLDOWN_BASE),
      .CD_W          (CD_W),
      .MAX_ACTIVE    (MAX_ACTIVE),
      .LIFETIME      (LIFETIME),
      .LIFE_W        (LIFE_W)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .game_active  (game_active),
      .level        (level),
      .rand_in      (rand_in),
      .kill         (kill),
      .monster      (monster),
      .spawn_pulse  (spawn_pulse),
      .spawn_lane   (spawn_lane),
      .active_count (active_count),
      .timeout      (timeout)
   );

   // Timeline model: tracks the edge number of the next lane evaluation, a pending grant and lane birth times.
   int       m_t, m_eval_at, m_pend_lane, m_last, m_lane;
   bit       m_run, m_pend, m_pulse;
   bit [3:0] m_occ, m_to, m_nxt, m_cand;
   int       m_born [4];

   function automatic int cd_cycles(input logic [1:0] lv);
      int c;
      c = COOLDOWN_BASE >> lv;
      return (c < 1) ? 1 : c;
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_t = 0; m_run = 0; m_pend = 0; m_occ = 0; m_to = 0;
         m_pulse = 0; m_lane = 0; m_last = 3; m_eval_at = 0; m_pend_lane = 0;
      end else begin
         m_t++;
         m_pulse = 0;
         m_to = 0;
         if (!game_active) begin
            m_run = 0; m_pend = 0; m_occ = 0;
         end else if (!m_run) begin
            m_run = 1;
            m_eval_at = m_t + cd_cycles(level) + 1;
         end else begin
            m_nxt = m_occ;
            for (int i = 0; i < 4; i++) begin
               if (m_occ[i]) begin
                  if (kill[i]) m_nxt[i] = 1'b0;
                  else if (TIMEOUT_ON && (m_t - m_born[i] >= LIFETIME)) begin
                     m_nxt[i] = 1'b0;
                     m_to[i] = 1'b1;
                  end
               end
            end
            if (m_pend) begin
               m_nxt[m_pend_lane] = 1'b1;
               m_born[m_pend_lane] = m_t;
               m_pulse = 1;
               m_lane = m_pend_lane;
               m_last = m_pend_lane;
               m_pend = 0;
               m_eval_at = m_t + cd_cycles(level) + 1;
            end else if (m_t >= m_eval_at) begin
               m_cand = rand_in & ~m_occ;
               if (m_cand != 0 && $countones(m_occ) < MAX_ACTIVE) begin
                  for (int k = 1; k <= 4; k++) begin
                     if (!m_pend && m_cand[(m_last + k) % 4]) begin
                        m_pend = 1;
                        m_pend_lane = (m_last + k) % 4;
                     end
                  end
               end
            end
            m_occ = m_nxt;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
      end
   endtask

   task automatic apply_stimulus(input logic ga, input logic [1:0] lv, input logic [3:0] rnd, input logic [3:0] kl);
      @(negedge Clk);
      game_active = ga;
      level       = lv;
      rand_in     = rnd;
      kill        = kl;
   endtask

   task automatic run_edges(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      game_active = 1'b0; level = 2'd0; rand_in = 4'h0; kill = 4'h0;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   typedef struct {
      bit       ga;
      bit [1:0] lvl;
      bit [3:0] rnd;
      bit [3:0] kil;
      int       n;
      bit [3:0] mon;
      bit       pul;
      bit [1:0] ln;
      bit [2:0] cnt;
   } vec_t;

   vec_t vecs [11];
   bit   seen;

   initial begin
      Reset = 1'b1;
      game_active = 1'b0; level = 2'd0; rand_in = 4'h0; kill = 4'h0;
      @(negedge Clk);
      @(negedge Clk);
      check("reset_state", {monster, spawn_pulse, spawn_lane, active_count, timeout}, 14'h0);
      Reset = 1'b0;

      vecs[0] = '{1'b1, 2'd0, 4'hF, 4'h0, 10, 4'b0000, 1'b0, 2'd0, 3'd0};
      vecs[1] = '{1'b1, 2'd0, 4'hF, 4'h0,  1, 4'b0001, 1'b1, 2'd0, 3'd1};
      vecs[2] = '{1'b1, 2'd0, 4'hF, 4'h0,  1, 4'b0001, 1'b0, 2'd0, 3'd1};
      vecs[3] = '{1'b1, 2'd0, 4'hF, 4'h0,  9, 4'b0011, 1'b1, 2'd1, 3'd2};
`ifdef NEXYS_STARSHIP_SPAWN_TIMEOUT_EN
      vecs[4]  = '{1'b1, 2'd0, 4'hF, 4'h0, 10, 4'b0110, 1'b1, 2'd2, 3'd2};
      vecs[5]  = '{1'b1, 2'd0, 4'hF, 4'h0, 10, 4'b1100, 1'b1, 2'd3, 3'd2};
      vecs[6]  = '{1'b1, 2'd0, 4'hF, 4'h0, 19, 4'b1001, 1'b0, 2'd0, 3'd2};
      vecs[7]  = '{1'b1, 2'd0, 4'hF, 4'h1,  1, 4'b0010, 1'b1, 2'd1, 3'd1};
      vecs[8]  = '{1'b1, 2'd0, 4'hF, 4'h1,  1, 4'b0010, 1'b0, 2'd1, 3'd1};
      vecs[9]  = '{1'b1, 2'd0, 4'hF, 4'h0,  1, 4'b0010, 1'b0, 2'd1, 3'd1};
      vecs[10] = '{1'b0, 2'd0, 4'hF, 4'h0,  1, 4'b0000, 1'b0, 2'd1, 3'd0};
`else
      vecs[4]  = '{1'b1, 2'd0, 4'hF, 4'h0, 10, 4'b0111, 1'b1, 2'd2, 3'd3};
      vecs[5]  = '{1'b1, 2'd0, 4'hF, 4'h0, 10, 4'b0111, 1'b0, 2'd2, 3'd3};
      vecs[6]  = '{1'b1, 2'd0, 4'hF, 4'h0, 19, 4'b0111, 1'b0, 2'd2, 3'd3};
      vecs[7]  = '{1'b1, 2'd0, 4'hF, 4'h1,  1, 4'b0110, 1'b0, 2'd2, 3'd2};
      vecs[8]  = '{1'b1, 2'd0, 4'hF, 4'h1,  1, 4'b0110, 1'b0, 2'd2, 3'd2};
      vecs[9]  = '{1'b1, 2'd0, 4'hF, 4'h0,  1, 4'b1110, 1'b1, 2'd3, 3'd3};
      vecs[10] = '{1'b0, 2'd0, 4'hF, 4'h0,  1, 4'b0000, 1'b0, 2'd3, 3'd0};
`endif

      // Kill is a one-edge pulse; the remaining edges of each entry run with kill cleared.
      for (int i = 0; i < 11; i++) begin
         apply_stimulus(vecs[i].ga, vecs[i].lvl, vecs[i].rnd, vecs[i].kil);
         @(posedge Clk);
         #1;
         kill = 4'h0;
         repeat (vecs[i].n - 1) begin
            @(posedge Clk);
            #1;
         end
         check($sformatf("vec%0d", i), {monster, spawn_pulse, spawn_lane, active_count},
               {vecs[i].mon, vecs[i].pul, vecs[i].ln, vecs[i].cnt});
      end

      do_reset();
      apply_stimulus(1'b1, 2'd3, 4'h0, 4'h0);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge Clk);
         #1;
         seen = seen | spawn_pulse | (|monster);
      end
      check("pick_hold_no_spawn", 32'(seen), 32'h0);
      apply_stimulus(1'b1, 2'd3, 4'b0100, 4'h0);
      run_edges(1);
      check("pick_grant_cycle", {monster, spawn_pulse}, 5'h0);
      run_edges(1);
      check("pick_lane2_spawn", {monster, spawn_pulse, spawn_lane}, {4'b0100, 1'b1, 2'd2});

      do_reset();
      apply_stimulus(1'b1, 2'd3, 4'hF, 4'h0);
      run_edges(6);
      check("pre_reset_spawn", {monster, spawn_lane, active_count}, {4'b0001, 2'd0, 3'd1});
      Reset = 1'b1;
      #1;
      check("async_reset_outputs", {monster, spawn_pulse, spawn_lane, active_count, timeout}, 14'h0);
      @(negedge Clk);
      Reset = 1'b0;
      run_edges(3);
      check("post_reset_no_early", {monster, spawn_pulse}, 5'h0);
      run_edges(1);
      check("post_reset_lane0", {monster, spawn_pulse, spawn_lane}, {4'b0001, 1'b1, 2'd0});

      do_reset();
      apply_stimulus(1'b1, 2'd0, 4'hF, 4'h0);
      run_edges(21);
      check("two_lanes_up", {monster, spawn_pulse, spawn_lane}, {4'b0011, 1'b1, 2'd1});
      run_edges(3);
      apply_stimulus(1'b0, 2'd0, 4'hF, 4'h0);
      run_edges(1);
      check("stop_clears", {monster, spawn_pulse, active_count}, 8'h0);
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge Clk);
         #1;
         seen = seen | spawn_pulse | (|timeout);
      end
      check("stopped_no_pulse", 32'(seen), 32'h0);

      do_reset();
      apply_stimulus(1'b1, 2'd0, 4'b0010, 4'h0);
      run_edges(11);
      check("lane1_spawn", {monster, spawn_pulse, spawn_lane}, {4'b0010, 1'b1, 2'd1});
      apply_stimulus(1'b1, 2'd0, 4'h0, 4'h0);
      run_edges(19);
      check("lifetime_pre", {monster, timeout}, {4'b0010, 4'b0000});
      run_edges(1);
`ifdef NEXYS_STARSHIP_SPAWN_TIMEOUT_EN
      check("lifetime_expiry", {monster, timeout}, {4'b0000, 4'b0010});
`else
      check("lifetime_expiry", {monster, timeout}, {4'b0010, 4'b0000});
`endif
      run_edges(1);
      check("timeout_one_cycle", 32'(timeout), 32'h0);

      do_reset();
      apply_stimulus(1'b1, 2'd0, 4'b0010, 4'h0);
      run_edges(11);
      apply_stimulus(1'b1, 2'd0, 4'h0, 4'h0);
      run_edges(19);
      apply_stimulus(1'b1, 2'd0, 4'h0, 4'b0010);
      run_edges(1);
      check("kill_beats_timeout", {monster, timeout}, 8'h0);
      kill = 4'h0;

      do_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge Clk);
         if ($urandom_range(0, 399) == 0) begin
            Reset = 1'b1;
            #1;
            check("random_async_reset", {monster, spawn_pulse, spawn_lane, active_count, timeout}, 14'h0);
            #1;
            Reset = 1'b0;
         end
         game_active = ($urandom_range(0, 39) != 0);
         level       = 2'($urandom_range(0, 3));
         rand_in     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) kill[i] = ($urandom_range(0, 23) == 0);
         @(posedge Clk);
         #1;
         check("random_vs_model", {monster, spawn_pulse, spawn_lane, active_count, timeout},
               {m_occ, m_pulse, 2'(m_lane), 3'($countones(m_occ)), m_to});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
